// File: rtl/soc_debug_display.sv
// Snapshot display for Soc_Mips debug outputs: captures on each step edge, shows one 16-bit page
// on a multiplexed 4-digit 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module soc_debug_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [2:0]       sel,
  input  logic [5:0]       PCout,
  input  logic [31:0]      Instruction,
  input  logic [7:0]       ALUResult,
  input  logic [7:0]       Data,
  input  logic [7:0]       readd1,
  input  logic [7:0]       readd2,
  input  logic [7:0]       WriteBack,
  input  logic [2:0]       writer,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             RegWrite,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RTerm = RW'(REFRESH_DIV - 1);

  logic             r_step_prev;
  logic [5:0]       r_pc;
  logic [31:0]      r_instr;
  logic [7:0]       r_alu, r_data, r_rd1, r_rd2, r_wb;
  logic [2:0]       r_writer;
  logic             r_mem_read, r_mem_write, r_reg_write;
  logic [CNT_W-1:0] r_step_count;
  logic [RW-1:0]    r_refresh;
  logic [1:0]       r_scan;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;

  logic        w_step_ev;
  logic [15:0] w_cnt16;
  logic [15:0] w_page;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg_nx;
  logic        w_dp_nx;

  assign w_step_ev  = step & ~r_step_prev;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign step_count = r_step_count;

  generate
    if (CNT_W >= 16) begin : g_cnt_trunc
      assign w_cnt16 = r_step_count[15:0];
    end else begin : g_cnt_ext
      assign w_cnt16 = {{(16 - CNT_W){1'b0}}, r_step_count};
    end
  endgenerate

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    w_page = 16'h0000;
    case (sel)
      3'd0: w_page = {2'b00, r_pc, w_cnt16[7:0]};
      3'd1: w_page = r_instr[31:16];
      3'd2: w_page = r_instr[15:0];
      3'd3: w_page = {r_rd1, r_rd2};
      3'd4: w_page = {r_alu, r_data};
      3'd5: w_page = {5'b00000, r_writer, r_wb};
      3'd6: w_page = w_cnt16;
      default: w_page = 16'h0000;
    endcase

    w_nib   = 4'h0;
    w_dp_nx = 1'b1;
    case (r_scan)
      2'd0: w_nib = w_page[3:0];
      2'd1: begin w_nib = w_page[7:4];   w_dp_nx = ~r_mem_read;  end
      2'd2: begin w_nib = w_page[11:8];  w_dp_nx = ~r_mem_write; end
      default: begin w_nib = w_page[15:12]; w_dp_nx = ~r_reg_write; end
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only when it and everything above it is zero.
    w_blank = ((r_scan == 2'd3) && (w_page[15:12] == 4'h0)) ||
              ((r_scan == 2'd2) && (w_page[15:8] == 8'h00)) ||
              ((r_scan == 2'd1) && (w_page[15:4] == 12'h000));
`else
    w_blank = 1'b0;
`endif

    w_seg_nx = w_blank ? 7'b1111111 : hex7(w_nib);
    if (sel == 3'd7) begin
      w_seg_nx = 7'b1111111;
      w_dp_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_prev  <= 1'b0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_alu        <= '0;
      r_data       <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_wb         <= '0;
      r_writer     <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_step_count <= '0;
      r_refresh    <= '0;
      r_scan       <= 2'd0;
      r_seg        <= 7'b1000000;
      r_dp         <= 1'b1;
      r_an         <= 4'b1110;
    end else begin
      r_step_prev <= step;
      if (w_step_ev) begin
        r_pc         <= PCout;
        r_instr      <= Instruction;
        r_alu        <= ALUResult;
        r_data       <= Data;
        r_rd1        <= readd1;
        r_rd2        <= readd2;
        r_wb         <= WriteBack;
        r_writer     <= writer;
        r_mem_read   <= MemRead;
        r_mem_write  <= MemWrite;
        r_reg_write  <= RegWrite;
        r_step_count <= r_step_count + CNT_W'(1);
      end
      if (r_refresh == RTerm) begin
        r_refresh <= '0;
        r_scan    <= r_scan + 2'd1;
      end else begin
        r_refresh <= r_refresh + RW'(1);
      end
      r_seg <= w_seg_nx;
      r_dp  <= w_dp_nx;
      r_an  <= ~(4'b0001 << r_scan);
    end
  end

endmodule

// File: tb/tb_soc_debug_display.sv
// Bench for soc_debug_display: directed steps plus randomized captures checked against a page model.
module tb_soc_debug_display;

  logic        clk = 1'b0, rst = 1'b0, step = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [5:0]  PCout = '0;
  logic [31:0] Instruction = '0;
  logic [7:0]  ALUResult = '0, Data = '0, readd1 = '0, readd2 = '0, WriteBack = '0;
  logic [2:0]  writer = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0;

  logic [6:0]  seg1, seg2;
  logic        dp1, dp2;
  logic [3:0]  an1, an2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  int n_pass = 0;
  int n_total = 0;

  // Model of the captured snapshot and total number of steps issued.
  logic [5:0]  m_pc;
  logic [31:0] m_instr;
  logic [7:0]  m_alu, m_data, m_rd1, m_rd2, m_wb;
  logic [2:0]  m_writer;
  logic        m_mr, m_mw, m_rw;
  int unsigned m_cnt;

  logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  soc_debug_display #(.REFRESH_DIV(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .step(step), .sel(sel), .PCout(PCout), .Instruction(Instruction),
    .ALUResult(ALUResult), .Data(Data), .readd1(readd1), .readd2(readd2),
    .WriteBack(WriteBack), .writer(writer), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .seg(seg1), .dp(dp1), .an(an1), .step_count(cnt1)
  );

  // Narrow counter instance so wrap-around is reachable in a short run.
  soc_debug_display #(.REFRESH_DIV(4), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .step(step), .sel(sel), .PCout(PCout), .Instruction(Instruction),
    .ALUResult(ALUResult), .Data(Data), .readd1(readd1), .readd2(readd2),
    .WriteBack(WriteBack), .writer(writer), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .seg(seg2), .dp(dp2), .an(an2), .step_count(cnt2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_pc = '0; m_instr = '0; m_alu = '0; m_data = '0; m_rd1 = '0; m_rd2 = '0; m_wb = '0;
    m_writer = '0; m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0; m_cnt = 0;
  endtask

  task automatic rand_inputs();
    PCout = 6'($urandom); Instruction = $urandom; ALUResult = 8'($urandom);
    Data = 8'($urandom); readd1 = 8'($urandom); readd2 = 8'($urandom);
    WriteBack = 8'($urandom); writer = 3'($urandom);
    MemRead = 1'($urandom); MemWrite = 1'($urandom); RegWrite = 1'($urandom);
  endtask

  // Raise step, hold it for extra cycles while inputs churn, then drop it.
  task automatic do_step(input int hold);
    m_pc = PCout; m_instr = Instruction; m_alu = ALUResult; m_data = Data;
    m_rd1 = readd1; m_rd2 = readd2; m_wb = WriteBack; m_writer = writer;
    m_mr = MemRead; m_mw = MemWrite; m_rw = RegWrite; m_cnt++;
    step = 1'b1;
    tick();
    for (int i = 0; i < hold; i++) begin
      rand_inputs();
      tick();
    end
    step = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [15:0] exp_page(input logic [2:0] s, input logic [15:0] c);
    case (s)
      3'd0: return {2'b00, m_pc, c[7:0]};
      3'd1: return m_instr[31:16];
      3'd2: return m_instr[15:0];
      3'd3: return {m_rd1, m_rd2};
      3'd4: return {m_alu, m_data};
      3'd5: return {5'd0, m_writer, m_wb};
      3'd6: return c;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_disp(input string tag, input logic [6:0] s, input logic d,
                            input logic [3:0] a, input logic [15:0] c);
    int idx;
    logic [15:0] val;
    logic [6:0] e_seg;
    logic e_dp;
    logic blank;
    idx = -1;
    for (int i = 0; i < 4; i++) if (a == ~(4'b0001 << i)) idx = i;
    chk({tag, "_an_onehot"}, 32'(idx >= 0), 32'd1);
    if (idx < 0) return;
    val = exp_page(sel, c);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != 0) && ((val >> (4 * idx)) == 16'd0);
`endif
    e_seg = (sel == 3'd7 || blank) ? 7'h7F : hex_lut[(val >> (4 * idx)) & 16'hF];
    case (idx)
      3: e_dp = ~m_rw;
      2: e_dp = ~m_mw;
      1: e_dp = ~m_mr;
      default: e_dp = 1'b1;
    endcase
    if (sel == 3'd7) e_dp = 1'b1;
    chk({tag, "_seg"}, 32'(s), 32'(e_seg));
    chk({tag, "_dp"}, 32'(d), 32'(e_dp));
  endtask

  task automatic check_both(input string tag);
    check_disp(tag, seg1, dp1, an1, 16'(m_cnt));
    check_disp({tag, "_w4"}, seg2, dp2, an2, 16'(m_cnt % 16));
    chk({tag, "_cnt"}, 32'(cnt1), m_cnt & 32'hFFFF);
    chk({tag, "_cnt_w4"}, 32'(cnt2), m_cnt % 16);
  endtask

  task automatic scan(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_both(tag);
    end
  endtask

  // After reset release each digit is held for four clocks, starting from digit 0.
  task automatic an_seq(input string tag);
    logic [3:0] e;
    for (int k = 1; k <= 17; k++) begin
      tick();
      e = ~(4'b0001 << (((k - 1) / 4) % 4));
      chk({tag, "_an"}, 32'(an1), 32'(e));
      chk({tag, "_an_w4"}, 32'(an2), 32'(e));
    end
  endtask

  initial begin
    model_clear();
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", 32'(an1), 32'hE);
      chk("rst_seg", 32'(seg1), 32'h40);
      chk("rst_dp", 32'(dp1), 32'd1);
      chk("rst_cnt", 32'(cnt1), 32'd0);
    end
    rst = 1'b0;
    an_seq("init");

    PCout = 6'h05;
    do_step(0);
    sel = 3'd0;
    scan("pc5", 16);

    PCout = 6'h11;
    step = 1'b1;
    m_pc = PCout; m_cnt++;
    tick();
    for (int i = 0; i < 9; i++) begin
      PCout = 6'h3F;
      tick();
    end
    step = 1'b0;
    tick();
    tick();
    scan("held", 16);

    Instruction = 32'h20020005;
    do_step(0);
    sel = 3'd1;
    scan("ins_hi", 16);
    sel = 3'd2;
    tick();
    check_both("sel_latency");
    scan("ins_lo", 16);

    RegWrite = 1'b1; MemWrite = 1'b0; MemRead = 1'b1;
    do_step(0);
    sel = 3'd0;
    scan("flags", 16);
    sel = 3'd7;
    scan("blank", 16);

    for (int r = 0; r < 20; r++) begin
      rand_inputs();
      do_step(int'($urandom_range(0, 4)));
      rand_inputs();
      sel = 3'($urandom_range(0, 7));
      tick();
      check_both("rnd_next");
      scan("rnd", 8);
    end

    while ((m_cnt % 16) != 0) begin
      rand_inputs();
      do_step(0);
    end
    sel = 3'd6;
    scan("wrap", 16);

    repeat (6) tick();
    rst = 1'b1;
    #1;
    model_clear();
    chk("arst_an", 32'(an1), 32'hE);
    chk("arst_cnt", 32'(cnt1), 32'd0);
    tick();
    rst = 1'b0;
    an_seq("rerun");
    sel = 3'd0;
    scan("cleared", 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soc_debug_display.md
Name: soc_debug_display

Overview:
- Board-side consumer of the Soc_Mips debug outputs: PCout, Instruction, ALUResult, Data, readd1/readd2, WriteBack, writer and the control flags.
- Takes a snapshot of those signals each time the processor is stepped, counts steps, and shows one selectable 16-bit page on a 4-digit multiplexed 7-segment display.
- Control flags are shown on the decimal points.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit in the scan; legal range ≥2.
- CNT_W, 16: width of the step counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- step  in  1  processor clock/step level, synchronous to clk; its rising edge marks a processor step
- sel  in  3  page select
- PCout  in  6  program counter
- Instruction  in  32  current instruction
- ALUResult  in  8  ALU output
- Data  in  8  memory read data
- readd1  in  8  register read data 1
- readd2  in  8  register read data 2
- WriteBack  in  8  write-back value
- writer  in  3  write register index
- MemRead, MemWrite, RegWrite  in  1 each  control flags
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  4  digit anodes, active-low one-hot; an[0] is the least significant digit
- step_count  out  CNT_W  number of steps captured

Behaviour:
- Clock and reset: single clock domain. rst asynchronously clears every register.
- Reset values:
  - an=4'b1110
  - seg=7'b1000000 ("0")
  - dp=1
  - step_count=0
  - snapshot=0, step_prev=0, scan index=0, refresh counter=0
- Step detection:
  - step_prev is registered every cycle.
  - A step event is step & ~step_prev.
  - A level held high counts once only.
- On a step event, in the same edge:
  - Every data and flag input is latched into the snapshot registers.
  - step_count increments, wrapping 2^CNT_W-1 → 0.
- Input changes without a step event never alter the snapshot.
- Page map, on snapshot values (digit3..digit0):
  - 0: {2'b00,PC} , step_count[7:0]
  - 1: Instruction[31:16]
  - 2: Instruction[15:0]
  - 3: readd1 , readd2
  - 4: ALUResult , Data
  - 5: {5'b0,writer} , WriteBack
  - 6: step_count[15:0], zero-extended when CNT_W<16
  - 7: blank; seg=7'b1111111 on all digits, dp=1
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - At the terminal count it returns to 0 and the scan index advances 0→1→2→3→0.
- Outputs seg, dp and an are registered.
  - They reflect the current scan index, sel and snapshot with exactly one cycle of latency.
  - A page change or new snapshot therefore appears on the next clock without waiting for a scan wrap.
- Hex decode (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Decimal points on pages 0-6:
  - dp=0 on digit3 if RegWrite is captured.
  - dp=0 on digit2 if MemWrite is captured.
  - dp=0 on digit1 if MemRead is captured.
  - Otherwise dp=1. Digit0 dp is always 1.
- Simultaneous events: rst dominates a step event. A step event coinciding with a scan advance performs both.
- Reset mid-scan: the scan restarts at digit 0 on the first clock after release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined, on pages 0-6 digits 3..1 that are zero and more significant than every nonzero digit show seg=7'b1111111. Digit0 always shows its value. The dp rule is unchanged.
- When undefined, all four digits always show their hex value.

Test Plan:
- Reset with rst high for 3 cycles, then release (REFRESH_DIV=4):
  - During reset: an=1110, seg=1000000, dp=1, step_count=0.
  - After release: an sequences 1110→1101→1011→0111→1110, changing every 4 clocks.
- PCout=6'h05, one step rising edge, sel=0 → step_count=1; digits: d0 "1" (1111001), d1 "0", d2 "5" (0010010), d3 "0".
- step held high 10 cycles, then low → step_count increments by exactly 1. Changing PCout to 6'h3F while step stays high leaves page 0 at 05.
- Instruction=32'h20020005 captured by a step:
  - sel=1 → d3..d0 = 2,0,0,2.
  - sel=2 → 0,0,0,5.
  - The new page appears one clock after sel changes.
- RegWrite=1, MemWrite=0, MemRead=1 captured → dp=0 only while an=0111 or an=1101. sel=7 → seg=1111111 and dp=1 on all digits.
- CNT_W=16, issue 65536 steps → step_count wraps to 0; page 6 shows 0000. With LEADING_ZERO_BLANK_EN, page 6 shows d3..d1 blank and d0 "0".
